// File: rtl/i2s_line_in_rx.sv
// I2S line-in receiver: deserializes codec ADC data into parallel left/right samples.
// Define I2S_RX_MONO_EN to add the registered mono_out = (left+right)>>>1 output.
`timescale 1ns/1ps

module i2s_line_in_rx #(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i2s_bclk,
  input  logic                    i2s_lrclk,
  input  logic                    i2s_sdata,
  input  logic                    err_clear,
  output logic [SAMPLE_WIDTH-1:0] left_out,
  output logic [SAMPLE_WIDTH-1:0] right_out,
  output logic                    sample_valid,
`ifdef I2S_RX_MONO_EN
  output logic [SAMPLE_WIDTH-1:0] mono_out,
`endif
  output logic                    frame_err
);

  localparam int CW = $clog2(SAMPLE_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PAD} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  bclk_sync_q, bclk_sync_d;
  logic [SYNC_STAGES-1:0]  lr_sync_q, lr_sync_d;
  logic [SYNC_STAGES-1:0]  sd_sync_q, sd_sync_d;
  logic                    bclk_prev_q, bclk_prev_d;
  logic                    lr_prev_q, lr_prev_d;
  logic                    lr_seen_q, lr_seen_d;
  logic                    chan_q, chan_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic [SAMPLE_WIDTH-1:0] left_hold_q, left_hold_d;
  logic                    have_left_q, have_left_d;
  logic [SAMPLE_WIDTH-1:0] right_word_q, right_word_d;
  logic                    pend_q, pend_d;
  logic [SAMPLE_WIDTH-1:0] left_out_q, left_out_d;
  logic [SAMPLE_WIDTH-1:0] right_out_q, right_out_d;
  logic                    sample_valid_q, sample_valid_d;
  logic                    frame_err_q, frame_err_d;
`ifdef I2S_RX_MONO_EN
  logic [SAMPLE_WIDTH-1:0] mono_q, mono_d;
  logic [SAMPLE_WIDTH:0]   mono_sum;
`endif

  logic                    bclk_s, lr_s, sd_s;
  logic                    bclk_rise, lr_edge, err_set;
  logic [CW-1:0]           pad_bits;
  logic [SAMPLE_WIDTH-1:0] closed_word;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      bclk_sync_q    <= '0;
      lr_sync_q      <= '0;
      sd_sync_q      <= '0;
      bclk_prev_q    <= 1'b0;
      lr_prev_q      <= 1'b0;
      lr_seen_q      <= 1'b0;
      chan_q         <= 1'b0;
      cnt_q          <= '0;
      shift_q        <= '0;
      left_hold_q    <= '0;
      have_left_q    <= 1'b0;
      right_word_q   <= '0;
      pend_q         <= 1'b0;
      left_out_q     <= '0;
      right_out_q    <= '0;
      sample_valid_q <= 1'b0;
      frame_err_q    <= 1'b0;
`ifdef I2S_RX_MONO_EN
      mono_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      bclk_sync_q    <= bclk_sync_d;
      lr_sync_q      <= lr_sync_d;
      sd_sync_q      <= sd_sync_d;
      bclk_prev_q    <= bclk_prev_d;
      lr_prev_q      <= lr_prev_d;
      lr_seen_q      <= lr_seen_d;
      chan_q         <= chan_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      left_hold_q    <= left_hold_d;
      have_left_q    <= have_left_d;
      right_word_q   <= right_word_d;
      pend_q         <= pend_d;
      left_out_q     <= left_out_d;
      right_out_q    <= right_out_d;
      sample_valid_q <= sample_valid_d;
      frame_err_q    <= frame_err_d;
`ifdef I2S_RX_MONO_EN
      mono_q         <= mono_d;
`endif
    end
  end

  // lrclk and sdata are taken from the same synchronizer stage as bclk so bit alignment holds.
  always_comb begin
    bclk_sync_d = {bclk_sync_q[SYNC_STAGES-2:0], i2s_bclk};
    lr_sync_d   = {lr_sync_q[SYNC_STAGES-2:0], i2s_lrclk};
    sd_sync_d   = {sd_sync_q[SYNC_STAGES-2:0], i2s_sdata};
    bclk_s      = bclk_sync_q[SYNC_STAGES-1];
    lr_s        = lr_sync_q[SYNC_STAGES-1];
    sd_s        = sd_sync_q[SYNC_STAGES-1];
    bclk_prev_d = bclk_s;
    bclk_rise   = bclk_s & ~bclk_prev_q;
    lr_edge     = lr_seen_q & (lr_s != lr_prev_q);
    pad_bits    = CW'(SAMPLE_WIDTH) - cnt_q;
    closed_word = shift_q << pad_bits;

    state_d      = state_q;
    lr_prev_d    = lr_prev_q;
    lr_seen_d    = lr_seen_q;
    chan_d       = chan_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    left_hold_d  = left_hold_q;
    have_left_d  = have_left_q;
    right_word_d = right_word_q;
    pend_d       = 1'b0;
    err_set      = 1'b0;

    if (bclk_rise) begin
      lr_prev_d = lr_s;
      lr_seen_d = 1'b1;
      if (lr_edge) begin
        // Leaving IDLE closes nothing; otherwise the finished slot is committed here.
        if (state_q != IDLE) begin
          if (cnt_q < CW'(SAMPLE_WIDTH)) begin
            err_set = 1'b1;
          end
          if (!chan_q) begin
            left_hold_d = closed_word;
            have_left_d = 1'b1;
          end else begin
            have_left_d = 1'b0;
            if (have_left_q) begin
              pend_d       = 1'b1;
              right_word_d = closed_word;
            end
          end
        end
        state_d = SHIFT;
        cnt_d   = '0;
        shift_d = '0;
        chan_d  = lr_s;
      end else if (state_q == SHIFT) begin
        shift_d = {shift_q[SAMPLE_WIDTH-2:0], sd_s};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(SAMPLE_WIDTH - 1)) begin
          state_d = PAD;
        end
      end
    end

    frame_err_d = err_set ? 1'b1 : (err_clear ? 1'b0 : frame_err_q);

    sample_valid_d = pend_q;
    left_out_d     = left_out_q;
    right_out_d    = right_out_q;
    if (pend_q) begin
      left_out_d  = left_hold_q;
      right_out_d = right_word_q;
    end
`ifdef I2S_RX_MONO_EN
    mono_sum = {left_hold_q[SAMPLE_WIDTH-1], left_hold_q} + {right_word_q[SAMPLE_WIDTH-1], right_word_q};
    mono_d   = pend_q ? SAMPLE_WIDTH'(mono_sum >> 1) : mono_q;
`endif
  end

  assign left_out     = left_out_q;
  assign right_out    = right_out_q;
  assign sample_valid = sample_valid_q;
  assign frame_err    = frame_err_q;
`ifdef I2S_RX_MONO_EN
  assign mono_out     = mono_q;
`endif

endmodule

// File: tb/tb_i2s_line_in_rx.sv
// Directed testbench for i2s_line_in_rx: table-driven frames plus multi-cycle corner sequences.
// Mono checks are active when I2S_RX_MONO_EN is defined.
`timescale 1ns/1ps

module tb_i2s_line_in_rx;

   typedef struct {
      logic [31:0] lWord;
      logic [31:0] rWord;
      int          lBits;
      int          rBits;
      int          halfNs;
      logic [23:0] expLeft;
      logic [23:0] expRight;
      logic [23:0] expMono;
      logic        expErr;
   } vec_t;

   logic        clk;
   logic        reset_n;
   logic        i2s_bclk;
   logic        i2s_lrclk;
   logic        i2s_sdata;
   logic        err_clear;
   logic [23:0] left_out;
   logic [23:0] right_out;
   logic        sample_valid;
   logic        frame_err;
`ifdef I2S_RX_MONO_EN
   logic [23:0] mono_out;
`endif

   int testsRun    = 0;
   int testsFailed = 0;
   int pulseCount  = 0;
   int doublePulse = 0;
   int halfNs      = 40;
   logic prevValid = 1'b0;

   vec_t vecs[8];

   i2s_line_in_rx #(.SAMPLE_WIDTH(24), .SYNC_STAGES(2)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .i2s_bclk     (i2s_bclk),
      .i2s_lrclk    (i2s_lrclk),
      .i2s_sdata    (i2s_sdata),
      .err_clear    (err_clear),
      .left_out     (left_out),
      .right_out    (right_out),
      .sample_valid (sample_valid),
`ifdef I2S_RX_MONO_EN
      .mono_out     (mono_out),
`endif
      .frame_err    (frame_err)
   );

   // 100 MHz system clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count valid pulses and flag any pulse wider than one clock
   always @(negedge clk) begin
      if (sample_valid) begin
         pulseCount++;
         if (prevValid) doublePulse++;
      end
      prevValid = sample_valid;
   end

   task checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task sendBit(input logic lr, input logic sd);
      i2s_lrclk = lr;
      i2s_sdata = sd;
      #(halfNs);
      i2s_bclk = 1'b1;
      #(halfNs);
      i2s_bclk = 1'b0;
   endtask

   // Data bits MSB-first, then pad ones up to count rises
   task sendData(input logic lr, input logic [31:0] word, input int nbits, input int count);
      for (int i = 0; i < count; i++) begin
         sendBit(lr, (i < nbits) ? word[nbits-1-i] : 1'b1);
      end
   endtask

   // Left data (transition already sent), right slot, then the closing left transition
   task sendFrame(input logic [31:0] l, input logic [31:0] r, input int lb, input int rb);
      sendData(1'b0, l, lb, (lb < 24) ? lb : 31);
      sendBit(1'b1, 1'b1);
      sendData(1'b1, r, rb, (rb < 24) ? rb : 31);
      sendBit(1'b0, 1'b1);
   endtask

   task applyStimulus(input vec_t v);
      halfNs = v.halfNs;
      sendFrame(v.lWord, v.rWord, v.lBits, v.rBits);
      #200;
   endtask

   task pulseErrClear();
      @(posedge clk);
      #1 err_clear = 1'b1;
      @(posedge clk);
      #1 err_clear = 1'b0;
   endtask

   initial begin
      int startCount;
      int firstHigh;
      int highCount;
      logic [31:0] nWord;

      vecs[0] = '{32'h000001, 32'hFFFFFF, 24, 24, 40,  24'h000001, 24'hFFFFFF, 24'h000000, 1'b0};
      vecs[1] = '{32'h123456, 32'hABCDEF, 24, 24, 160, 24'h123456, 24'hABCDEF, 24'hDF0122, 1'b0};
      vecs[2] = '{32'h00A5A5, 32'h654321, 16, 24, 40,  24'hA5A500, 24'h654321, 24'h057410, 1'b1};
      vecs[3] = '{32'h7FFFFF, 32'h000001, 24, 24, 40,  24'h7FFFFF, 24'h000001, 24'h400000, 1'b0};
      vecs[4] = '{32'h800000, 32'h800000, 24, 24, 40,  24'h800000, 24'h800000, 24'h800000, 1'b0};
      vecs[5] = '{32'h000003, 32'h000000, 24, 24, 40,  24'h000003, 24'h000000, 24'h000001, 1'b0};
      vecs[6] = '{32'h000010, 32'h0000C3, 24, 8,  40,  24'h000010, 24'hC30000, 24'hE18008, 1'b1};
      vecs[7] = '{32'h123456, 32'hABCDEF, 24, 24, 160, 24'h123456, 24'hABCDEF, 24'hDF0122, 1'b0};

      reset_n   = 1'b0;
      i2s_bclk  = 1'b0;
      i2s_lrclk = 1'b1;
      i2s_sdata = 1'b0;
      err_clear = 1'b0;

      #22;
      checkOutput("reset left_out", {8'h0, left_out}, 32'h0);
      checkOutput("reset right_out", {8'h0, right_out}, 32'h0);
      checkOutput("reset sample_valid", {31'h0, sample_valid}, 32'h0);
      checkOutput("reset frame_err", {31'h0, frame_err}, 32'h0);
`ifdef I2S_RX_MONO_EN
      checkOutput("reset mono_out", {8'h0, mono_out}, 32'h0);
`endif
      #30 reset_n = 1'b1;

      // Released mid-right-word: partial right bits, then the first left transition
      halfNs = 40;
      for (int i = 0; i < 6; i++) sendBit(1'b1, i[0]);
      sendBit(1'b0, 1'b1);
      #200;
      checkOutput("partial right no pulse", pulseCount, 0);

      for (int i = 0; i < 8; i++) begin
         pulseErrClear();
         startCount = pulseCount;
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d pulse count", i), pulseCount - startCount, 1);
         checkOutput($sformatf("vec%0d left_out", i), {8'h0, left_out}, {8'h0, vecs[i].expLeft});
         checkOutput($sformatf("vec%0d right_out", i), {8'h0, right_out}, {8'h0, vecs[i].expRight});
         checkOutput($sformatf("vec%0d frame_err", i), {31'h0, frame_err}, {31'h0, vecs[i].expErr});
`ifdef I2S_RX_MONO_EN
         checkOutput($sformatf("vec%0d mono_out", i), {8'h0, mono_out}, {8'h0, vecs[i].expMono});
`endif
      end

      // Sticky error cleared by err_clear
      halfNs = 40;
      pulseErrClear();
      sendFrame(32'h000010, 32'h0000C3, 24, 8);
      #200;
      checkOutput("short right sets err", {31'h0, frame_err}, 32'h1);
      pulseErrClear();
      checkOutput("err_clear clears", {31'h0, frame_err}, 32'h0);

      // Short left word whose close coincides with err_clear; set must win
      sendData(1'b0, 32'h5A5A, 16, 16);
      i2s_lrclk = 1'b1;
      i2s_sdata = 1'b1;
      #40;
      @(posedge clk);
      #1 i2s_bclk = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 err_clear = 1'b1;
      @(posedge clk);
      #1 err_clear = 1'b0;
      #20 i2s_bclk = 1'b0;
      #20;
      checkOutput("err set beats clear", {31'h0, frame_err}, 32'h1);
      sendData(1'b1, 32'h13579B, 24, 31);

      // Closing rise placed just after a clk edge to measure pulse latency
      startCount = pulseCount;
      i2s_lrclk = 1'b0;
      i2s_sdata = 1'b1;
      #40;
      @(posedge clk);
      #1 i2s_bclk = 1'b1;
      firstHigh = 0;
      highCount = 0;
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk);
         #1;
         if (sample_valid) begin
            highCount++;
            if (firstHigh == 0) firstHigh = k;
         end
      end
      i2s_bclk = 1'b0;
      #100;
      checkOutput("valid latency", firstHigh, 4);
      checkOutput("valid width", highCount, 1);
      checkOutput("collision left_out", {8'h0, left_out}, 32'h5A5A00);
      checkOutput("collision right_out", {8'h0, right_out}, 32'h13579B);

      // Reset in the middle of a left word after a valid frame
      sendData(1'b0, 32'h111111, 24, 10);
      reset_n = 1'b0;
      #1;
      checkOutput("midreset left_out", {8'h0, left_out}, 32'h0);
      checkOutput("midreset right_out", {8'h0, right_out}, 32'h0);
      checkOutput("midreset sample_valid", {31'h0, sample_valid}, 32'h0);
      checkOutput("midreset frame_err", {31'h0, frame_err}, 32'h0);
`ifdef I2S_RX_MONO_EN
      checkOutput("midreset mono_out", {8'h0, mono_out}, 32'h0);
`endif
      #20 reset_n = 1'b1;
      startCount = pulseCount;
      sendData(1'b0, 32'h111111, 24, 21);
      sendBit(1'b1, 1'b1);
      sendData(1'b1, 32'h222222, 24, 31);
      sendBit(1'b0, 1'b1);
      #200;
      checkOutput("recovery orphan right", pulseCount - startCount, 0);
      sendFrame(32'h0ABCDE, 32'h765432, 24, 24);
      #200;
      checkOutput("recovery pulse count", pulseCount - startCount, 1);
      checkOutput("recovery left_out", {8'h0, left_out}, 32'h0ABCDE);
      checkOutput("recovery right_out", {8'h0, right_out}, 32'h765432);

      // 48 back-to-back frames, L=n, R=~n
      for (int n = 0; n < 48; n++) begin
         startCount = pulseCount;
         nWord = 32'(n);
         sendFrame(nWord, ~nWord & 32'hFFFFFF, 24, 24);
         #100;
         checkOutput($sformatf("stream%0d pulse", n), pulseCount - startCount, 1);
         checkOutput($sformatf("stream%0d left", n), {8'h0, left_out}, nWord);
         checkOutput($sformatf("stream%0d right", n), {8'h0, right_out}, ~nWord & 32'hFFFFFF);
      end

      checkOutput("no double-wide pulse", doublePulse, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
